// File: rtl/rc_add_sub_32_pkg.sv
// Shared data-width constants and types for the ripple-carry adder/subtractor.
// Latency: n/a (definitions only).
// Backpressure: n/a (no flow control in this block).
package rc_add_sub_32_pkg;

  localparam int DATA_WIDTH       = 32;
  localparam int DATA_INDEX_LIMIT = 31;

  typedef logic [DATA_INDEX_LIMIT:0] data_t;

  // Operating mode as carried on SnA; the mode bit doubles as carry-in to bit 0.
  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

endpackage

// File: rtl/rc_add_sub_32_if.sv
// Operand/result bundle between the datapath and the adder/subtractor.
// Latency: n/a (wires only).
// Backpressure: none; a new operation is accepted every cycle.
interface rc_add_sub_32_if;
  import rc_add_sub_32_pkg::*;

  data_t A;
  data_t B;
  logic  SnA;
  data_t Y;
  logic  CO;

  // Operand source side.
  modport master (output A, output B, output SnA, input Y, input CO);
  // Arithmetic unit side.
  modport slave  (input A, input B, input SnA, output Y, output CO);

endinterface

// File: rtl/rc_add_sub_32_full_adder.sv
// One-bit full adder, the ripple cell of the carry chain.
// Latency: combinational.
// Backpressure: none.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/rc_add_sub_32.sv
// Registered 32-bit ripple-carry add/subtract: Y = A+B (SnA=0) or A-B (SnA=1), CO = carry out of bit 31.
// Latency: 1 cycle; one operation per cycle, 32-stage ripple settles within one period.
// Backpressure: none; inputs are sampled on every rising CLK while RST is high.
module rc_add_sub_32
  import rc_add_sub_32_pkg::*;
(
  input  logic           CLK,
  input  logic           RST,
  rc_add_sub_32_if.slave bus
);

  data_t                 b_eff;
  data_t                 sum;
  logic [DATA_WIDTH:0]   carry;

  // Two's complement subtract: invert B and inject SnA as the carry-in.
  assign b_eff    = bus.B ^ {DATA_WIDTH{bus.SnA}};
  assign carry[0] = bus.SnA;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_chain
    full_adder u_fa (
      .a  (bus.A[i]),
      .b  (b_eff[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  // Output register; async clear drops results immediately while RST is low.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bus.Y  <= '0;
      bus.CO <= 1'b0;
    end else begin
      bus.Y  <= sum;
      bus.CO <= carry[DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_rc_add_sub_32.sv
// Scoreboard bench for rc_add_sub_32: directed vectors with hand-computed results.
// Latency: expects each result one rising edge after its operands are driven.
// Backpressure: none; stimulus and checking run as separate processes.
module tb_rc_add_sub_32;

  typedef struct {
    logic [31:0] y;
    logic        co;
    string       name;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  rc_add_sub_32_if bus ();

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   stim_done = 1'b0;

  rc_add_sub_32 dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] ay, input logic aco,
                       input logic [31:0] ey, input logic eco);
    total++;
    if (ay !== ey || aco !== eco) begin
      bad++;
      $display("FAIL %s: got Y=%h CO=%b, want Y=%h CO=%b", nm, ay, aco, ey, eco);
    end
  endtask

  // Drive operands on the falling edge and queue the result due after the next rise.
  task automatic issue(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic sna, input logic [31:0] ey, input logic eco);
    exp_t e;
    @(negedge CLK);
    bus.A   = a;
    bus.B   = b;
    bus.SnA = sna;
    e.y = ey; e.co = eco; e.name = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: one result per rising edge for every queued operation.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, bus.Y, bus.CO, e.y, e.co);
      end
    end
  end

  initial begin
    bus.A = 32'h0; bus.B = 32'h0; bus.SnA = 1'b0;

    // Reset held with traffic on the inputs.
    #2 RST = 1'b0;
    bus.A = 32'hDEADBEEF; bus.B = 32'h12345678; bus.SnA = 1'b1;
    repeat (3) @(posedge CLK);
    #1 check("reset_hold", bus.Y, bus.CO, 32'h0, 1'b0);

    @(negedge CLK);
    RST = 1'b1;
    #1 check("reset_release_pre_edge", bus.Y, bus.CO, 32'h0, 1'b0);

    issue("add_3_4",        32'd3,          32'd4,          1'b0, 32'd7,          1'b0);
    issue("add_wrap_ff_1",  32'hFFFFFFFF,   32'd1,          1'b0, 32'h0,          1'b1);
    issue("add_wrap_msb",   32'h80000000,   32'h80000000,   1'b0, 32'h0,          1'b1);
    issue("add_mixed",      32'h12345678,   32'h0FEDCBA8,   1'b0, 32'h22222220,   1'b0);
    issue("add_ff_ff",      32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'hFFFFFFFE,   1'b1);
    issue("sub_5_3",        32'd5,          32'd3,          1'b1, 32'd2,          1'b1);
    issue("sub_0_0",        32'd0,          32'd0,          1'b1, 32'd0,          1'b1);
    issue("sub_3_5",        32'd3,          32'd5,          1'b1, 32'hFFFFFFFE,   1'b0);
    issue("sub_0_1",        32'd0,          32'd1,          1'b1, 32'hFFFFFFFF,   1'b0);
    issue("sub_msb_1",      32'h80000000,   32'd1,          1'b1, 32'h7FFFFFFF,   1'b1);

    // Alternate mode every cycle with fixed operands.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) issue("switch_add", 32'd10, 32'd4, 1'b0, 32'd14, 1'b0);
      else            issue("switch_sub", 32'd10, 32'd4, 1'b1, 32'd6,  1'b1);
    end

    // Reset between edges while a result is held.
    issue("pre_reset_101", 32'd100, 32'd1, 1'b0, 32'd101, 1'b0);
    @(posedge CLK);
    #3;
    RST = 1'b0;
    #1 check("reset_async_clear", bus.Y, bus.CO, 32'h0, 1'b0);
    repeat (2) @(posedge CLK);
    #1 check("reset_mid_hold", bus.Y, bus.CO, 32'h0, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    #1 check("reset_mid_release_pre_edge", bus.Y, bus.CO, 32'h0, 1'b0);
    issue("post_reset_add", 32'd100, 32'd1, 1'b0, 32'd101, 1'b0);
    issue("post_reset_sub", 32'd100, 32'd1, 1'b1, 32'd99,  1'b1);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d results still outstanding, want 0", exp_q.size());
    end

    stim_done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
